// File: rtl/crc_p2_cpu_ocimem_sequencer.sv
// Sysclk-side sequencer turning OCI-memory debug strobes into single-word read/write
// transactions on a waitrequest-style debug RAM port, with auto-increment and stall timeout.
module crc_p2_cpu_ocimem_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    output logic [ADDR_W-1:0] MonAReg,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   stall_cnt;
    logic [ADDR_W-1:0]  jdo_addr;
    logic               any_strobe;
    logic               unused_jdo_bits;

    assign jdo_addr        = jdo[ADDR_W+1:2];
    assign any_strobe      = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign unused_jdo_bits = &{1'b0, jdo[37:36], jdo[1:0]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            stall_cnt     <= '0;
            MonAReg       <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            mem_address   <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_action_ocimem_a) begin
                        MonAReg <= jdo_addr;
                        // An address-only load leaves ready and the sticky error untouched.
                        if (jdo[35]) begin
                            mem_address   <= jdo_addr;
                            mem_read      <= 1'b1;
                            monitor_ready <= 1'b0;
                            monitor_error <= 1'b0;
                            stall_cnt     <= '0;
                            state         <= READ;
                        end
                    end else if (take_action_ocimem_b) begin
                        mem_address   <= MonAReg;
                        mem_writedata <= jdo[34:3];
                        mem_write     <= 1'b1;
                        monitor_ready <= 1'b0;
                        monitor_error <= 1'b0;
                        stall_cnt     <= '0;
                        state         <= WRITE;
                    end else if (take_no_action_ocimem_a) begin
                        mem_address   <= MonAReg;
                        mem_read      <= 1'b1;
                        monitor_ready <= 1'b0;
                        monitor_error <= 1'b0;
                        stall_cnt     <= '0;
                        state         <= READ;
                    end
                end
                READ, WRITE: begin
                    // Commands arriving mid-transaction are dropped and flagged as overrun.
                    if (any_strobe) begin
                        monitor_error <= 1'b1;
                    end
                    if (!mem_waitrequest) begin
                        mem_read      <= 1'b0;
                        mem_write     <= 1'b0;
                        monitor_ready <= 1'b1;
                        MonAReg       <= MonAReg + ADDR_W'(1);
                        if (state == READ) begin
                            MonDReg <= mem_readdata;
                        end
                        state <= IDLE;
                    end else if (stall_cnt == CNT_W'(TIMEOUT - 1)) begin
                        mem_read      <= 1'b0;
                        mem_write     <= 1'b0;
                        monitor_ready <= 1'b1;
                        monitor_error <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    mem_read      <= 1'b0;
                    mem_write     <= 1'b0;
                    monitor_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_p2_cpu_ocimem_sequencer.sv
// Randomized self-checking bench for crc_p2_cpu_ocimem_sequencer using a
// transaction-level model of address, read data and sticky error.
module tb_crc_p2_cpu_ocimem_sequencer;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic [37:0]       jdo;
    logic [ADDR_W-1:0] MonAReg;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata;
    logic              mem_waitrequest;

    crc_p2_cpu_ocimem_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .jdo                     (jdo),
        .MonAReg                 (MonAReg),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .mem_address             (mem_address),
        .mem_read                (mem_read),
        .mem_write               (mem_write),
        .mem_writedata           (mem_writedata),
        .mem_readdata            (mem_readdata),
        .mem_waitrequest         (mem_waitrequest)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: what the debug module should see after each command.
    logic [7:0]  m_addr;
    logic [31:0] m_dreg;
    logic        m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic clear_strobes();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_req"},   {mem_read, mem_write}, 2'b00);
        check({tag, "_ready"}, monitor_ready, 1'b1);
        check({tag, "_error"}, monitor_error, m_err);
        check({tag, "_areg"},  MonAReg, m_addr);
        check({tag, "_dreg"},  MonDReg, m_dreg);
    endtask

    // ocimem_a with jdo[35]=0, optionally colliding with ocimem_b.
    task automatic load_addr(input logic [7:0] addr, input bit also_b);
        jdo       = {$urandom, $urandom};
        jdo[35]   = 1'b0;
        jdo[9:2]  = addr;
        take_action_ocimem_a = 1'b1;
        take_action_ocimem_b = also_b;
        @(posedge clk); #1;
        clear_strobes();
        m_addr = addr;
        check_state("load");
        @(posedge clk); #1;
        check("load_no_req", {mem_read, mem_write}, 2'b00);
    endtask

    // kind 0: ocimem_a read, 1: ocimem_b write, 2: read-next. k = stall cycles before accept.
    task automatic run_txn(input int kind, input logic [7:0] addr, input logic [31:0] data,
                           input int k, input bit ovr);
        logic [7:0]  ea;
        logic [31:0] rd;
        int          hold;
        int          inj;
        int          which;
        bit          acc;
        ea   = (kind == 0) ? addr : m_addr;
        rd   = $urandom;
        acc  = (k < TIMEOUT);
        hold = acc ? k + 1 : TIMEOUT;
        inj  = ovr ? int'($urandom_range(hold - 1, 0)) : -1;
        jdo  = '0;
        if (kind == 0) begin
            jdo[35]  = 1'b1;
            jdo[9:2] = addr;
        end
        if (kind == 1) jdo[34:3] = data;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
        @(posedge clk); #1;
        clear_strobes();
        check("start_error", monitor_error, 1'b0);
        for (int c = 0; c < hold; c++) begin
            check("req_kind", {mem_read, mem_write}, (kind == 1) ? 2'b01 : 2'b10);
            check("req_ready", monitor_ready, 1'b0);
            check("req_addr", mem_address, ea);
            if (kind == 1) check("req_wdata", mem_writedata, data);
            mem_waitrequest = (c < k);
            mem_readdata    = (c < k) ? $urandom : rd;
            if (c == inj) begin
                which = $urandom_range(2, 0);
                jdo   = {$urandom, $urandom};
                take_action_ocimem_a    = (which == 0);
                take_action_ocimem_b    = (which == 1);
                take_no_action_ocimem_a = (which == 2);
            end
            @(posedge clk); #1;
            clear_strobes();
        end
        mem_waitrequest = 1'b0;
        if (acc) begin
            m_err  = ovr;
            m_addr = ea + 8'd1;
            if (kind != 1) m_dreg = rd;
        end else begin
            m_err  = 1'b1;
            m_addr = ea;
        end
        check_state(acc ? "done" : "abort");
    endtask

    initial begin
        int kind;
        int r;
        int k;
        reset_n         = 1'b0;
        jdo             = '0;
        mem_readdata    = '0;
        mem_waitrequest = 1'b0;
        clear_strobes();
        m_addr = '0;
        m_dreg = '0;
        m_err  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_state("reset");

        // Directed cases.
        run_txn(0, 8'h10, 32'h0, 0, 1'b0);
        load_addr(8'hFF, 1'b0);
        run_txn(1, 8'h00, 32'h12345678, 3, 1'b0);
        check("wrap_areg", MonAReg, 8'h00);
        run_txn(2, 8'h00, 32'h0, TIMEOUT + 2, 1'b0);
        load_addr(8'h40, 1'b0);
        run_txn(2, 8'h00, 32'h0, 2, 1'b1);
        run_txn(0, 8'h20, 32'h0, 1, 1'b0);
        load_addr(8'h33, 1'b1);
        run_txn(0, 8'h50, 32'h0, TIMEOUT - 1, 1'b0);

        // Reset in the middle of a stalled read.
        take_no_action_ocimem_a = 1'b1;
        mem_waitrequest         = 1'b1;
        @(posedge clk); #1;
        clear_strobes();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n         = 1'b1;
        mem_waitrequest = 1'b0;
        m_addr = '0;
        m_dreg = '0;
        m_err  = 1'b0;
        check_state("midreset");

        // Random command stream.
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(2, 0);
            r    = $urandom_range(11, 0);
            k    = (r == 11) ? TIMEOUT + int'($urandom_range(3, 0)) :
                   (r == 10) ? TIMEOUT - 1 : int'($urandom_range(3, 0));
            if ($urandom_range(4, 0) == 0) load_addr(8'($urandom), 1'($urandom));
            run_txn(kind, 8'($urandom), $urandom, k, ($urandom_range(5, 0) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
